// File: rtl/fwd_pkg.sv
// Shared widths, selection encoding and helpers for the operand forwarding stage.
package fwd_pkg;

    localparam int W_DEF  = 64;
    localparam int AW_DEF = 5;

    // Selection code for the register-file path; source i is encoded as i+1.
    localparam int SEL_RF = 0;

    function automatic int sel_idx_to_src(input int sel);
        return sel - 1;
    endfunction

endpackage

// File: rtl/fwd_prio_sel.sv
// Address/write-enable match against every forwarding source with youngest-first
// (lowest index) priority. Shared by the rs1 and rs2 operand instances.
module fwd_prio_sel #(
    parameter int AW      = fwd_pkg::AW_DEF,
    parameter int NUM_SRC = 3,
    parameter int IW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [AW-1:0]         rs_addr,
    input  logic [NUM_SRC*AW-1:0] src_rd_addr,
    input  logic [NUM_SRC-1:0]    src_we,
    output logic                  hit,
    output logic [IW-1:0]         idx
);

    always_comb begin
        // NOTE: defaults on every comb output before any branch prevent latch inference.
        hit = 1'b0;
        idx = '0;
        // Walk oldest to youngest so the youngest match is the last one written.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_we[i] && (src_rd_addr[i*AW +: AW] == rs_addr) && (rs_addr != '0)) begin
                hit = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/operand_fwd_stage.sv
// One source operand: forwarding select, load-use hazard detect and the
// registered ID/EX slot with stall, flush and a saturating forward counter.
module operand_fwd_stage
    import fwd_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int AW      = AW_DEF,
    parameter int NUM_SRC = 3,
    parameter int CW      = 16,
    parameter int SW      = $clog2(NUM_SRC + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  stall_in,
    input  logic                  flush,
    input  logic [AW-1:0]         rs_addr,
    input  logic [W-1:0]          rf_data,
    input  logic [NUM_SRC*AW-1:0] src_rd_addr,
    input  logic [NUM_SRC-1:0]    src_we,
    input  logic [NUM_SRC*W-1:0]  src_data,
    input  logic [NUM_SRC-1:0]    src_data_ok,
    output logic                  out_valid,
    output logic [W-1:0]          out_data,
    output logic [SW-1:0]         out_sel,
    output logic                  hazard_stall,
    output logic [CW-1:0]         fwd_count
);

    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [CW-1:0] COUNT_MAX = '1;

    logic          hit;
    logic [IW-1:0] idx;
    logic [SW-1:0] sel;
    logic [W-1:0]  sel_data;

    fwd_prio_sel #(
        .AW      (AW),
        .NUM_SRC (NUM_SRC),
        .IW      (IW)
    ) u_prio (
        .rs_addr     (rs_addr),
        .src_rd_addr (src_rd_addr),
        .src_we      (src_we),
        .hit         (hit),
        .idx         (idx)
    );

    always_comb begin
        sel      = SW'(SEL_RF);
        sel_data = rf_data;
        if (hit) begin
            sel      = SW'(idx) + SW'(1);
            sel_data = src_data[sel_idx_to_src(int'(sel))*W +: W];
        end
    end

    // Only the winning source's readiness matters; shadowed older sources are ignored.
    assign hazard_stall = in_valid & hit & ~src_data_ok[idx] & ~flush;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            fwd_count <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (stall_in) begin
            out_valid <= out_valid;
        end else if (hazard_stall) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else begin
            out_valid <= in_valid;
            out_data  <= sel_data;
            out_sel   <= sel;
            if (in_valid && (sel != SW'(SEL_RF)) && (fwd_count != COUNT_MAX))
                fwd_count <= fwd_count + CW'(1);
        end
    end

endmodule

// File: tb/tb_operand_fwd_stage.sv
// Directed bench for operand_fwd_stage (3 sources, 4-bit counter) with
// hand-computed expected values for each vector.
module tb_operand_fwd_stage;

    localparam int W       = 64;
    localparam int AW      = 5;
    localparam int NUM_SRC = 3;
    localparam int CW      = 4;
    localparam int SW      = 2;

    localparam logic [W-1:0] DA = 64'hAAAA_0000_0000_000A;
    localparam logic [W-1:0] DB = 64'hBBBB_0000_0000_000B;
    localparam logic [W-1:0] DC = 64'hCCCC_0000_0000_000C;
    localparam logic [W-1:0] DD = 64'hDDDD_0000_0000_000D;
    localparam logic [W-1:0] RF = 64'h1234_5678_9ABC_DEF0;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  stall_in;
    logic                  flush;
    logic [AW-1:0]         rs_addr;
    logic [W-1:0]          rf_data;
    logic [NUM_SRC*AW-1:0] src_rd_addr;
    logic [NUM_SRC-1:0]    src_we;
    logic [NUM_SRC*W-1:0]  src_data;
    logic [NUM_SRC-1:0]    src_data_ok;
    logic                  out_valid;
    logic [W-1:0]          out_data;
    logic [SW-1:0]         out_sel;
    logic                  hazard_stall;
    logic [CW-1:0]         fwd_count;

    int checks   = 0;
    int failures = 0;
    int exp_cnt;

    operand_fwd_stage #(
        .W       (W),
        .AW      (AW),
        .NUM_SRC (NUM_SRC),
        .CW      (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .stall_in     (stall_in),
        .flush        (flush),
        .rs_addr      (rs_addr),
        .rf_data      (rf_data),
        .src_rd_addr  (src_rd_addr),
        .src_we       (src_we),
        .src_data     (src_data),
        .src_data_ok  (src_data_ok),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_sel      (out_sel),
        .hazard_stall (hazard_stall),
        .fwd_count    (fwd_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_slot(input string tag, input logic v, input logic [W-1:0] d,
                              input logic [SW-1:0] s, input int cnt);
        check({tag, ".valid"}, W'(out_valid), W'(v));
        check({tag, ".data"},  out_data, d);
        check({tag, ".sel"},   W'(out_sel), W'(s));
        check({tag, ".count"}, W'(fwd_count), W'(cnt));
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        stall_in    = 1'b0;
        flush       = 1'b0;
        rs_addr     = '0;
        rf_data     = RF;
        src_rd_addr = '0;
        src_we      = '0;
        src_data    = {DC, DB, DA};
        src_data_ok = 3'b111;

        tick();
        tick();
        check_slot("reset", 1'b0, '0, 2'd0, 0);
        check("reset.hazard", W'(hazard_stall), 0);
        rst = 1'b0;

        // All three sources match: youngest wins.
        in_valid    = 1'b1;
        rs_addr     = 5'd5;
        src_rd_addr = {5'd5, 5'd5, 5'd5};
        src_we      = 3'b111;
        #1 check("prio_all.hazard", W'(hazard_stall), 0);
        tick();
        check_slot("prio_all", 1'b1, DA, 2'd1, 1);

        src_we = 3'b110;
        tick();
        check_slot("prio_110", 1'b1, DB, 2'd2, 2);

        // x0 is never forwarded.
        rs_addr     = 5'd0;
        src_rd_addr = '0;
        src_we      = 3'b111;
        tick();
        check_slot("x0", 1'b1, RF, 2'd0, 2);

        rs_addr     = 5'd7;
        src_rd_addr = {5'd5, 5'd5, 5'd5};
        tick();
        check_slot("nomatch", 1'b1, RF, 2'd0, 2);

        // Load-use on the youngest source.
        rs_addr     = 5'd3;
        src_rd_addr = {5'd9, 5'd9, 5'd3};
        src_we      = 3'b001;
        src_data_ok = 3'b110;
        #1 check("loaduse.hazard", W'(hazard_stall), 1);
        tick();
        check_slot("loaduse.bubble", 1'b0, '0, 2'd0, 2);

        src_data_ok = 3'b111;
        #1 check("loaduse.ready_hazard", W'(hazard_stall), 0);
        tick();
        check_slot("loaduse.capture", 1'b1, DA, 2'd1, 3);

        // Non-ready older source shadowed by a ready younger match.
        src_rd_addr = {5'd9, 5'd3, 5'd3};
        src_we      = 3'b011;
        src_data_ok = 3'b101;
        #1 check("shadow.hazard", W'(hazard_stall), 0);
        tick();
        check_slot("shadow", 1'b1, DA, 2'd1, 4);

        // No hazard without a valid instruction.
        in_valid    = 1'b0;
        src_data_ok = 3'b110;
        #1 check("novalid.hazard", W'(hazard_stall), 0);
        in_valid    = 1'b1;
        src_data_ok = 3'b111;

        // Stall for three cycles with changing inputs: everything holds.
        stall_in = 1'b1;
        src_data = {DC, DB, DD};
        for (int i = 0; i < 3; i++) begin
            if (i == 1) src_data_ok = 3'b110;
            else        src_data_ok = 3'b111;
            #1 check("stall.hazard", W'(hazard_stall), W'(i == 1));
            tick();
            check_slot("stall", 1'b1, DA, 2'd1, 4);
        end

        // Flush beats stall and hazard.
        src_data_ok = 3'b110;
        flush       = 1'b1;
        #1 check("flush.hazard", W'(hazard_stall), 0);
        tick();
        check_slot("flush", 1'b0, '0, 2'd0, 4);
        flush       = 1'b0;
        stall_in    = 1'b0;
        src_data_ok = 3'b111;

        // Invalid capture still loads data/sel but does not count.
        in_valid = 1'b0;
        tick();
        check_slot("invalid_cap", 1'b0, DD, 2'd1, 4);

        // Saturation at 2^CW-1.
        in_valid = 1'b1;
        exp_cnt  = 4;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (exp_cnt < 15) exp_cnt++;
            check("sat.count", W'(fwd_count), W'(exp_cnt));
        end
        check("sat.final", W'(fwd_count), 15);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_slot("reset2", 1'b0, '0, 2'd0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/operand_fwd_stage.md
Name: operand_fwd_stage

Overview:
- Parametrised successor to the fixed 3:1 64-bit operand select used on the execute path.
- Selects one source operand from the register-file value or any of NUM_SRC forwarding stages, using address/write-enable compare with youngest-first priority.
- Detects a load-use hazard when the winning stage's data is not yet ready.
- Registers the result into an ID/EX-style pipeline slot with stall, flush and valid tracking.
- One instance per operand (rs1, rs2), between decode and execute.

Parameters:
- W, 64, operand data width.
- AW, 5, register address width.
- NUM_SRC, 3, number of forwarding sources; index 0 is youngest (EX/MEM), then MEM/WB, WB.
- CW, 16, width of the forwarding-event counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  decode slot holds a real instruction.
- stall_in  input  1  downstream hold; pipeline register keeps its contents.
- flush  input  1  kill the slot (branch mispredict / trap).
- rs_addr  input  AW  source register address.
- rf_data  input  W  register-file read data.
- src_rd_addr  input  NUM_SRC*AW  packed destination addresses; slice i is source i.
- src_we  input  NUM_SRC  source i will write rd.
- src_data  input  NUM_SRC*W  packed forwarding data.
- src_data_ok  input  NUM_SRC  source i data is available this cycle (0 = load still in flight).
- out_valid  output  1  registered slot valid.
- out_data  output  W  registered operand.
- out_sel  output  SW=$clog2(NUM_SRC+1)  registered selection; 0 = register file, i+1 = source i.
- hazard_stall  output  1  combinational request to stall decode.
- fwd_count  output  CW  saturating count of forwarded captures.

Behaviour:
- Match rule: source i matches when src_we[i]=1, src_rd_addr[i]=rs_addr and rs_addr!=0. Register x0 is never forwarded.
- Winner: the lowest matching index. If there is no match, sel=0 and data=rf_data.
- hazard_stall = in_valid & winner exists & src_data_ok[winner]=0 & ~flush. A non-ready older source that is shadowed by a younger match raises no hazard.
- Update priority at each posedge: rst > flush > stall_in > hazard > capture.
- rst: out_valid=0, out_data=0, out_sel=0, fwd_count=0.
- flush: out_valid=0, out_data=0, out_sel=0; fwd_count unchanged. Flush overrides stall_in and hazard.
- stall_in (no flush): all registers hold, including fwd_count. hazard_stall is still driven combinationally.
- hazard (no flush, no stall_in): insert a bubble: out_valid=0, out_data=0, out_sel=0; fwd_count unchanged.
- capture: out_valid<=in_valid, out_data<=selected data, out_sel<=sel.
- fwd_count increments on capture when in_valid=1 and sel!=0. It saturates at 2^CW-1 and never wraps.
- Latency: exactly 1 cycle from input to registered output. No combinational path from inputs to out_*.
- in_valid=0 on capture: out_valid=0, but data/sel are still loaded (don't-care for consumers); no count.
- NUM_SRC=1 is legal; SW is then 1. All packed slices are width-exact; no truncation or extension of data.

Decomposition:
- Package fwd_pkg holds:
  - default widths W_DEF=64, AW_DEF=5;
  - constant SEL_RF=0;
  - a function sel_idx_to_src(sel) that returns sel-1.
- One natural sub-module, fwd_prio_sel: combinational match and priority encoder. It takes rs_addr, src_rd_addr, src_we and returns a hit flag and winner index. It is reused by the rs1 and rs2 instances.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> out_valid=0, out_data=0, out_sel=0, fwd_count=0, hazard_stall=0.
- Priority: rs=5, src_rd=(5,5,5), we=111, all ok, src_data=(A,B,C), in_valid=1 -> next cycle out_data=A, out_sel=1, fwd_count=1. Repeat with we=110 -> out_data=B, out_sel=2.
- x0 and no-match: rs=0 with all sources matching rd=0 -> out_data=rf_data, out_sel=0, fwd_count unchanged. rs=7 with no match -> same result.
- Load-use: rs=3, src0 matches with data_ok=0 -> hazard_stall=1, next out_valid=0. Next cycle data_ok=1 -> capture of src0 data, out_valid=1.
- Stall/flush interplay: stall_in=1 for 3 cycles -> outputs and fwd_count frozen. flush=1 together with stall_in=1 and a hazard -> out_valid=0, hazard_stall=0.
- Saturation: CW=4, 20 consecutive forwarded captures -> fwd_count reaches 15 and stays at 15.
